// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division, one bit per clock.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 is_div_q, neg_q, neg_rem_q, dbz_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH:0]       rem_q;
  logic [WIDTH-1:0]     opb_q;
  logic                 busy_q, done_q, dbz_out_q;
  logic [WIDTH-1:0]     hi_q, lo_q;

  logic                 sa, sb;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       msum;
  logic [WIDTH+1:0]     dshift, diff;
  logic                 qbit;
  logic [2*WIDTH-1:0]   mul_d, div_d, prod;
  logic [WIDTH:0]       rem_d;
  logic [WIDTH-1:0]     quo_fin, rem_fin;

  function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
    return n ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2_if(input logic n, input logic [2*WIDTH-1:0] v);
    return n ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  always_comb begin
    // Sign extraction only for the signed ops; the most-negative value maps to itself, which is its correct unsigned magnitude.
    sa    = op[0] & src_a[WIDTH-1];
    sb    = op[0] & src_b[WIDTH-1];
    mag_a = neg_if(sa, src_a);
    mag_b = neg_if(sb, src_b);

    msum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_d = {msum, acc_q[WIDTH-1:1]};

    dshift = {rem_q, acc_q[WIDTH-1]};
    diff   = dshift - {2'b00, opb_q};
    qbit   = 1'b0;
    rem_d  = dshift[WIDTH:0];
    if (!diff[WIDTH+1]) begin
      qbit  = 1'b1;
      rem_d = diff[WIDTH:0];
    end
    div_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], qbit};

    prod    = neg2_if(neg_q, acc_q);
    quo_fin = neg_if(neg_q, acc_q[WIDTH-1:0]);
    rem_fin = neg_if(neg_rem_q, rem_q[WIDTH-1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULTU, OP_MULT: begin
                acc_q    <= {{WIDTH{1'b0}}, mag_b};
                opb_q    <= mag_a;
                neg_q    <= sa ^ sb;
                is_div_q <= 1'b0;
                dbz_q    <= 1'b0;
                cnt_q    <= CNT_W'(WIDTH);
                busy_q   <= 1'b1;
                state_q  <= S_RUN;
              end
              OP_DIVU, OP_DIV: begin
                acc_q     <= {{WIDTH{1'b0}}, mag_a};
                rem_q     <= '0;
                opb_q     <= mag_b;
                neg_q     <= sa ^ sb;
                neg_rem_q <= sa;
                is_div_q  <= 1'b1;
                dbz_q     <= (src_b == '0);
                cnt_q     <= CNT_W'(WIDTH);
                busy_q    <= 1'b1;
                state_q   <= (src_b == '0) ? S_FINISH : S_RUN;
              end
              OP_MTHI: begin
                hi_q   <= src_a;
                done_q <= 1'b1;
              end
              OP_MTLO: begin
                lo_q   <= src_a;
                done_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          acc_q <= is_div_q ? div_d : mul_d;
          if (is_div_q) rem_q <= rem_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= S_FINISH;
        end
        S_FINISH: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          dbz_out_q <= dbz_q;
          if (!dbz_q) begin
            if (is_div_q) begin
              hi_q <= rem_fin;
              lo_q <= quo_fin;
            end else begin
              hi_q <= prod[2*WIDTH-1:WIDTH];
              lo_q <= prod[WIDTH-1:0];
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_out_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (WIDTH=32) against an arithmetic model of HI/LO.
module tb_alu_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;
  logic         exp_dbz;
  int           exp_lat;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: architectural effect of one request, from plain arithmetic.
  task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    longint sa, sb, q, r;
    exp_dbz = 1'b0;
    exp_lat = W + 1;
    case (o)
      3'b000: begin
        p = {32'b0, a} * {32'b0, b};
        exp_hi = p[63:32]; exp_lo = p[31:0];
      end
      3'b001: begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        p = 64'(sa * sb);
        exp_hi = p[63:32]; exp_lo = p[31:0];
      end
      3'b010, 3'b011: begin
        if (b == 0) begin
          exp_dbz = 1'b1;
          exp_lat = 1;
        end else if (o == 3'b010) begin
          exp_lo = a / b; exp_hi = a % b;
        end else begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          q = sa / sb; r = sa % sb;
          exp_lo = q[31:0]; exp_hi = r[31:0];
        end
      end
      3'b100: begin exp_hi = a; exp_lat = 0; end
      3'b101: begin exp_lo = a; exp_lat = 0; end
      default: ;
    endcase
  endtask

  // Drives one request and waits (bounded) for done; returns in the done cycle.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output bit busy_ok);
    start = 1'b1; op = o; src_a = a; src_b = b;
    step();
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 40) begin
      if (!o[2] && !(o[1] && b == 0) && busy !== 1'b1) busy_ok = 1'b0;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0 || hi !== '0 || lo !== '0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b dbz=%b hi=%h lo=%h, required all zero", busy, done, div_by_zero, hi, lo);
    end
    reset = 1'b0;
    step();
    exp_hi = '0; exp_lo = '0;
  endtask

  task automatic test_directed();
    logic [2:0] ops [4] = '{3'b000, 3'b001, 3'b011, 3'b011};
    logic [W-1:0] as [4] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'h80000000};
    logic [W-1:0] bs [4] = '{32'd2, 32'd5, 32'd2, 32'hFFFFFFFF};
    logic [W-1:0] rh [4] = '{32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    logic [W-1:0] rl [4] = '{32'hFFFFFFFE, 32'hFFFFFFF1, 32'hFFFFFFFD, 32'h80000000};
    int lat; bit bok;
    for (int i = 0; i < 4; i++) begin
      model(ops[i], as[i], bs[i]);
      issue(ops[i], as[i], bs[i], lat, bok);
      checks++;
      if (lat !== W + 1 || !bok || busy !== 1'b0 || div_by_zero !== 1'b0 || hi !== rh[i] || lo !== rl[i]) begin
        failures++;
        $display("FAIL directed[%0d]: lat=%0d busy_ok=%b busy=%b dbz=%b hi=%h lo=%h, required lat=%0d 1 0 0 hi=%h lo=%h",
                 i, lat, bok, busy, div_by_zero, hi, lo, W + 1, rh[i], rl[i]);
      end
      step();
      checks++;
      if (done !== 1'b0 || div_by_zero !== 1'b0 || hi !== rh[i] || lo !== rl[i]) begin
        failures++;
        $display("FAIL directed_after[%0d]: done=%b dbz=%b hi=%h lo=%h, required done=0 dbz=0 hi/lo held", i, done, div_by_zero, hi, lo);
      end
    end
  endtask

  task automatic test_div_by_zero();
    int lat; bit bok;
    issue(3'b100, 32'h11111111, 32'h0, lat, bok);
    checks++;
    if (lat !== 0 || hi !== 32'h11111111 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mthi: lat=%0d hi=%h busy=%b, required lat=0 hi=11111111 busy=0", lat, hi, busy);
    end
    step();
    issue(3'b101, 32'h22222222, 32'h0, lat, bok);
    checks++;
    if (lat !== 0 || lo !== 32'h22222222 || hi !== 32'h11111111) begin
      failures++;
      $display("FAIL mtlo: lat=%0d hi=%h lo=%h, required lat=0 hi=11111111 lo=22222222", lat, hi, lo);
    end
    exp_hi = 32'h11111111; exp_lo = 32'h22222222;
    step();
    issue(3'b010, 32'd9, 32'd0, lat, bok);
    checks++;
    if (lat !== 1 || div_by_zero !== 1'b1 || busy !== 1'b0 || hi !== 32'h11111111 || lo !== 32'h22222222) begin
      failures++;
      $display("FAIL div0: lat=%0d dbz=%b busy=%b hi=%h lo=%h, required lat=1 dbz=1 busy=0 hi=11111111 lo=22222222",
               lat, div_by_zero, busy, hi, lo);
    end
    step();
    checks++;
    if (done !== 1'b0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL div0_pulse: done=%b dbz=%b, required 0 0", done, div_by_zero);
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    start = 1'b1; op = 3'b000; src_a = 32'd1234567; src_b = 32'd89;
    step();
    start = 1'b0;
    model(3'b000, 32'd1234567, 32'd89);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (lat == 3) begin start = 1'b1; op = 3'b011; src_a = 32'hFFFFFF00; src_b = 32'd0; end
      if (lat == 12) start = 1'b0;
      step();
      lat++;
    end
    start = 1'b0;
    checks++;
    if (lat !== W + 1 || hi !== exp_hi || lo !== exp_lo || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL busy_restart: lat=%0d hi=%h lo=%h dbz=%b, required lat=%0d hi=%h lo=%h dbz=0",
               lat, hi, lo, div_by_zero, W + 1, exp_hi, exp_lo);
    end
    step();
  endtask

  task automatic test_reset_mid_op();
    bit seen_done;
    start = 1'b1; op = 3'b000; src_a = 32'hFFFFFFFF; src_b = 32'd2;
    step();
    start = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    checks++;
    if (busy !== 1'b0 || hi !== '0 || lo !== '0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h, required 0 0 0 0", busy, done, hi, lo);
    end
    seen_done = 1'b0;
    repeat (40) begin
      step();
      if (done === 1'b1 || busy !== 1'b0) seen_done = 1'b1;
    end
    checks++;
    if (seen_done || hi !== '0 || lo !== '0) begin
      failures++;
      $display("FAIL reset_mid_quiet: activity=%b hi=%h lo=%h, required activity=0 hi=0 lo=0", seen_done, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit bok; bit seen;
    model(3'b001, 32'hFFFFFFFA, 32'd7);
    issue(3'b001, 32'hFFFFFFFA, 32'd7, lat, bok);
    checks++;
    if (lat !== W + 1 || hi !== exp_hi || lo !== exp_lo) begin
      failures++;
      $display("FAIL b2b_first: lat=%0d hi=%h lo=%h, required lat=%0d hi=%h lo=%h", lat, hi, lo, W + 1, exp_hi, exp_lo);
    end
    issue(3'b010, 32'd100, 32'd7, lat, bok);
    checks++;
    if (lat !== W + 1 || !bok || lo !== 32'd14 || hi !== 32'd2 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL b2b_divu: lat=%0d busy_ok=%b hi=%h lo=%h dbz=%b, required lat=%0d 1 hi=2 lo=14 dbz=0",
               lat, bok, hi, lo, div_by_zero, W + 1);
    end
    exp_hi = 32'd2; exp_lo = 32'd14;
    for (int r = 6; r < 8; r++) begin
      start = 1'b1; op = 3'(r); src_a = $urandom; src_b = $urandom;
      step();
      start = 1'b0;
      seen = (done === 1'b1 || busy !== 1'b0);
      repeat (5) begin
        step();
        if (done === 1'b1 || busy !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen || hi !== exp_hi || lo !== exp_lo) begin
        failures++;
        $display("FAIL reserved[%0d]: activity=%b hi=%h lo=%h, required activity=0 hi=%h lo=%h", r, seen, hi, lo, exp_hi, exp_lo);
      end
    end
  endtask

  task automatic test_random();
    int lat; bit bok;
    logic [2:0] o;
    logic [W-1:0] a, b;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 5));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 9)); end
        3: b = b | 32'h80000000;
        default: ;
      endcase
      model(o, a, b);
      issue(o, a, b, lat, bok);
      checks++;
      if (lat !== exp_lat || !bok || busy !== 1'b0 || div_by_zero !== exp_dbz || hi !== exp_hi || lo !== exp_lo) begin
        failures++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: lat=%0d busy_ok=%b busy=%b dbz=%b hi=%h lo=%h, required lat=%0d 1 0 dbz=%b hi=%h lo=%h",
                 i, o, a, b, lat, bok, busy, div_by_zero, hi, lo, exp_lat, exp_dbz, exp_hi, exp_lo);
      end
      if ($urandom_range(0, 1) == 0) begin
        step();
        checks++;
        if (done !== 1'b0 || div_by_zero !== 1'b0) begin
          failures++;
          $display("FAIL random_pulse[%0d]: done=%b dbz=%b, required 0 0", i, done, div_by_zero);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_by_zero();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised multiply/divide unit. It is the sequential successor to the single-cycle ALU and sits beside it in the execute stage of the multicycle MIPS datapath.
- Performs MULT/MULTU/DIV/DIVU iteratively, one bit per clock, into architectural HI/LO registers.
- Also supports direct MTHI/MTLO writes.
- The controller uses a start/busy/done handshake to stall while an operation runs.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (>= 4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- op  input  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 11x reserved
- src_a  input  WIDTH  multiplicand / dividend / MTHI-MTLO data
- src_b  input  WIDTH  multiplier / divisor
- busy  output  1  operation in progress; start ignored
- done  output  1  one-cycle pulse; hi/lo hold the new result
- div_by_zero  output  1  valid with done; divide with src_b=0
- hi  output  WIDTH  HI register (product upper half / remainder)
- lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (synchronous, active-high, applied on any clock edge including mid-operation):
  - FSM goes to IDLE.
  - hi=0, lo=0, busy=0, done=0, div_by_zero=0.
  - Any in-flight operation is discarded.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - start=1 with op in 000..011: latch operand magnitudes and the signs, load counter=WIDTH, go to RUN, busy=1 from the next cycle.
  - Signed ops (MULT, DIV): operands are converted to magnitudes; the sign flags are recorded at the same time.
  - MTHI/MTLO: write src_a to hi/lo at the sampling edge. done=1 the following cycle; busy never asserts; FSM stays IDLE.
  - Reserved op: ignored; no done, no state change.
- Divide by zero (DIVU/DIV with src_b=0):
  - No RUN; FSM goes directly to FINISH.
  - hi/lo unchanged; done=1 and div_by_zero=1 for one cycle.
- RUN:
  - One iteration per edge; counter decrements each edge.
  - Multiply: shift-add, 2*WIDTH-bit accumulator.
  - Divide: restoring shift-subtract, remainder WIDTH+1 bits.
  - When counter reaches 0, go to FINISH.
- FINISH:
  - Single edge that applies sign correction and writes hi/lo.
  - Sets done=1 and busy=0; returns to IDLE.
- Latency for MUL/DIV, with start sampled at edge 0:
  - busy=1 after edges 0..WIDTH.
  - hi/lo updated and done=1 after edge WIDTH+1 (WIDTH+1 cycles total).
  - A new start is accepted in the done cycle.
- Sign rules:
  - MULT: product is negated if the operand signs differ.
  - DIV: quotient sign = sign_a XOR sign_b; remainder takes the dividend sign.
  - DIV of most-negative by -1: lo=most-negative (wraps), hi=0, div_by_zero=0.
- start while busy=1: ignored; operands and op are not re-latched.
- done and div_by_zero are single-cycle pulses and are 0 in every other cycle.
- hi/lo change only on:
  - the FINISH edge of a MUL/DIV with nonzero divisor,
  - an MTHI/MTLO edge,
  - reset.

Test Plan (WIDTH=32):
- MULTU src_a=0xFFFFFFFF, src_b=2 -> done after edge 33, hi=0x00000001, lo=0xFFFFFFFE, busy high after edges 0..32.
- MULT src_a=-3 (0xFFFFFFFD), src_b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV with signed operands:
  - src_a=-7, src_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - src_a=0x80000000, src_b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- Divide by zero: hi/lo preset to 0x11111111/0x22222222 via MTHI/MTLO (each done one cycle after its edge), then DIVU src_a=9, src_b=0 -> done and div_by_zero pulse after edge 1, hi/lo unchanged.
- start re-asserted with a different op during busy -> ignored; result matches the original op.
- reset at edge 10 of a MULTU -> busy=0, hi=lo=0, no done.
- Back-to-back requests:
  - DIVU 100/7 started in the done cycle of the previous op -> lo=14, hi=2.
  - Reserved op 110 -> no response.
